execute_md_stage: RTL and testbench
===================================

// Module: execute_md_stage
// PURPOSE
//  Parametrised EX pipeline stage: forwarding operand muxes, extended ALU, branch-target adder, EX/MEM register.
//  Adds an iterative multiply/divide unit with architectural HI/LO registers.
//  Adds a stall handshake to ID while mul/div is busy, and a flush input. Sits between ID/EX and MEM.
// PARAMETERS
//  XLEN      32  datapath width (even, >=8)
//  PC_W      10  PC / branch-adder width; sum wraps modulo 2^PC_W
//  RA_W      5   register-address width
//  CTRL_W    5   pass-through control bundle width {MemtoReg,RegWrite,read_en,write_en,branch}
// PORTS
//  clock          in   1       rising-edge clock
//  reset          in   1       asynchronous, active-high
//  ip_valid       in   1       instruction present in EX
//  ip_flush       in   1       kill EX instruction, abort mul/div
//  ip_alu_op      in   5       alu_op_e from exe_pkg
//  ip_alu_src     in   1       1: B operand = ip_immediate
//  ip_rs1_data    in   XLEN    register operand A
//  ip_rs2_data    in   XLEN    register operand B
//  ip_immediate   in   XLEN    sign-extended immediate
//  ip_shamt       in   5       shift amount; only low log2(XLEN) bits used
//  ip_pc_plus_4   in   PC_W    PC+4 of EX instruction
//  ip_dest_reg    in   RA_W    resolved destination register
//  ip_ctrl        in   CTRL_W  pass-through control
//  ip_fa, ip_fb   in   2       forwarding select: 00 reg, 10 MEM, 01 WB, 11 reg
//  ip_fwd_mem     in   XLEN    MEM-stage ALU result
//  ip_fwd_wb      in   XLEN    WB write data
//  op_stall       out  1       hold ID/EX and earlier stages
//  op_valid       out  1       EX/MEM holds a real instruction
//  op_alu_result  out  XLEN    registered ALU result
//  op_zero        out  1       registered (alu_result == 0)
//  op_add_result  out  PC_W    registered branch target
//  op_mem_wdata   out  XLEN    registered forwarded rs2
//  op_dest_reg    out  RA_W    registered destination
//  op_ctrl        out  CTRL_W  registered control bundle, zero when bubble
// BEHAVIOUR
//  Reset
//  - All outputs 0; FSM IDLE; HI = LO = 0; counter 0.
//  Operand muxes
//  - Forwarding selects rs1/rs2 first; the ALUSrc mux follows on the B path.
//  - Store data = forwarded rs2, independent of ALUSrc.
//  ALU ops, 1 cycle
//  - AND, OR, XOR, NOR, ADD, SUB: wrap modulo 2^XLEN, no overflow trap.
//  - SLT (signed), SLTU (unsigned): result 0 or 1.
//  - SLL, SRL, SRA by shamt; SLLV, SRLV, SRAV by A[log2 XLEN-1:0].
//  - MFHI, MFLO: result = HI, LO.
//  Branch target
//  - add_result = pc_plus_4 + (imm << 2), truncated to PC_W.
//  EX/MEM register
//  - Normal: loads sig_* each edge.
//  - Loads a bubble (valid=0, ctrl=0, data=0) if !ip_valid, ip_flush, or op_stall.
//  Mul/div FSM: IDLE -> BUSY -> IDLE
//  - Start: IDLE with ip_valid & !ip_flush & op in {MULT, MULTU, DIV, DIVU}.
//  - On the start edge the instruction passes to EX/MEM as valid, with result 0 and ctrl as given (RegWrite expected 0).
//  - Operands are latched and the counter is set to XLEN-1.
//  - BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes).
//  - Counter==0: sign-corrected HI/LO written on that edge, then IDLE.
//  - Latency: XLEN cycles start-to-IDLE; op_stall = (state == BUSY), combinational.
//  - A dependent MFHI/MFLO waits in EX and completes on the first IDLE cycle with the new HI/LO.
//  - MULT/MULTU: {HI,LO} = full 2*XLEN product.
//  - DIV/DIVU: LO = quotient, HI = remainder; remainder sign = dividend sign.
//  - Divide by zero: LO = all ones, HI = dividend; no trap.
//  - Signed INT_MIN / -1: LO = INT_MIN, HI = 0.
//  Simultaneous events
//  - ip_flush in BUSY: abort to IDLE next edge; HI/LO unchanged; op_stall drops the following cycle.
//  - ip_flush on a start cycle: no start.
//  - Flush has priority over start and over capture.
//  - Reset mid-operation: immediate IDLE, HI/LO cleared.
// STRUCTURE
//  - Package exe_pkg: alu_op_e (5-bit enum), md_state_e {IDLE, BUSY}, fwd_sel_e, CTRL_W bit-index localparams.
//  - Sub-module muldiv_iter: FSM, counter, operand/accumulator registers, sign fix, HI/LO.
//  - muldiv_iter interface: start/flush/op/a/b in; busy/hi/lo out. Top keeps the ALU, muxes and EX/MEM register.
// TESTING (XLEN=32)
//  - ADD 0x7FFFFFFF + 1 -> 0x80000000, zero=0; SUB 5-5 -> 0, zero=1; SLT -1<1 -> 1; SLTU -> 0.
//  - FA=10, FB=01, ALUSrc=1, imm=4, mem=0x10, wb=0x99: ADD -> 0x14; mem_wdata = 0x99.
//  - MULT 0xFFFFFFFF*2 then MFHI, MFLO -> MFHI waits 32 cycles; HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
//  - DIV -7/2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 7/0 -> LO = 0xFFFFFFFF, HI = 7; DIV 0x80000000/-1 -> LO = 0x80000000, HI = 0.
//  - Flush in BUSY cycle 10 -> stall drops next cycle; HI/LO keep prior values; EX/MEM holds a bubble.
//  - Reset asserted asynchronously mid-BUSY -> outputs and HI/LO = 0 before the next edge; PC 0x3FC + imm 1<<2 wraps -> add_result = 0x000.

Source files
------------

// File: rtl/execute_md_stage_pkg.sv
// exe_pkg: shared ALU opcodes, mul/div FSM states, forwarding selects and control-bundle bit positions
package exe_pkg;
  typedef enum logic [4:0] {
    ALU_AND   = 5'd0,
    ALU_OR    = 5'd1,
    ALU_XOR   = 5'd2,
    ALU_NOR   = 5'd3,
    ALU_ADD   = 5'd4,
    ALU_SUB   = 5'd5,
    ALU_SLT   = 5'd6,
    ALU_SLTU  = 5'd7,
    ALU_SLL   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SRA   = 5'd10,
    ALU_SLLV  = 5'd11,
    ALU_SRLV  = 5'd12,
    ALU_SRAV  = 5'd13,
    ALU_MFHI  = 5'd14,
    ALU_MFLO  = 5'd15,
    ALU_MULT  = 5'd16,
    ALU_MULTU = 5'd17,
    ALU_DIV   = 5'd18,
    ALU_DIVU  = 5'd19
  } alu_op_e;
  typedef enum logic {IDLE, BUSY} md_state_e;
  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;
  localparam int CTRL_BRANCH   = 0;
  localparam int CTRL_WRITE_EN = 1;
  localparam int CTRL_READ_EN  = 2;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 4;
  function automatic logic is_md_op(alu_op_e o);
    return o inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction
endpackage

// File: rtl/execute_md_stage_muldiv_iter.sv
// muldiv_iter: radix-2 iterative multiply/divide on magnitudes with sign fix-up into HI/LO
module muldiv_iter
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int CW = $clog2(XLEN);
  md_state_e state;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] acc_hi, acc_lo, den, a_mag, b_mag, step_hi, step_lo, hi_fin, lo_fin;
  logic [XLEN:0] msum, rsh, rdiff;
  logic [2*XLEN-1:0] prod, pfix;
  logic is_div, neg_q, neg_r, div0, sgn, a_neg, b_neg, div_op;
  assign busy = state == BUSY;
  assign sgn = op == ALU_MULT || op == ALU_DIV;
  assign div_op = op == ALU_DIV || op == ALU_DIVU;
  assign a_neg = sgn && a[XLEN-1];
  assign b_neg = sgn && b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;
  // multiply: {acc_hi,acc_lo} shifts right, adding the multiplicand when the multiplier LSB is set
  assign msum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, den} : '0);
  // divide: shift the next dividend bit into the partial remainder and subtract if it fits
  assign rsh = {acc_hi, acc_lo[XLEN-1]};
  assign rdiff = rsh - {1'b0, den};
  assign step_hi = is_div ? (rdiff[XLEN] ? rsh[XLEN-1:0] : rdiff[XLEN-1:0]) : msum[XLEN:1];
  assign step_lo = is_div ? {acc_lo[XLEN-2:0], !rdiff[XLEN]} : {msum[0], acc_lo[XLEN-1:1]};
  assign prod = {step_hi, step_lo};
  assign pfix = neg_q ? -prod : prod;
  // divide by zero keeps the all-ones quotient that the restoring loop naturally produces
  assign hi_fin = !is_div ? pfix[2*XLEN-1:XLEN] : neg_r ? -step_hi : step_hi;
  assign lo_fin = !is_div ? pfix[XLEN-1:0] : div0 ? '1 : neg_q ? -step_lo : step_lo;
  // IDLE/BUSY sequencer: flush aborts without touching HI/LO, last step commits the result
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      den <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (state == IDLE) begin
      if (start) begin
        state <= BUSY;
        cnt <= CW'(XLEN - 1);
        is_div <= div_op;
        acc_hi <= '0;
        acc_lo <= div_op ? a_mag : b_mag;
        den <= div_op ? b_mag : a_mag;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        div0 <= b == '0;
      end
    end else begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt <= cnt - CW'(1);
      if (cnt == '0) begin
        state <= IDLE;
        hi <= hi_fin;
        lo <= lo_fin;
      end
    end
endmodule

// File: rtl/execute_md_stage.sv
// execute_md_stage: EX stage with forwarding muxes, ALU, branch adder, iterative mul/div and EX/MEM register
module execute_md_stage
  import exe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PC_W   = 10,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ip_valid,
  input  logic              ip_flush,
  input  logic [4:0]        ip_alu_op,
  input  logic              ip_alu_src,
  input  logic [XLEN-1:0]   ip_rs1_data,
  input  logic [XLEN-1:0]   ip_rs2_data,
  input  logic [XLEN-1:0]   ip_immediate,
  input  logic [4:0]        ip_shamt,
  input  logic [PC_W-1:0]   ip_pc_plus_4,
  input  logic [RA_W-1:0]   ip_dest_reg,
  input  logic [CTRL_W-1:0] ip_ctrl,
  input  logic [1:0]        ip_fa,
  input  logic [1:0]        ip_fb,
  input  logic [XLEN-1:0]   ip_fwd_mem,
  input  logic [XLEN-1:0]   ip_fwd_wb,
  output logic              op_stall,
  output logic              op_valid,
  output logic [XLEN-1:0]   op_alu_result,
  output logic              op_zero,
  output logic [PC_W-1:0]   op_add_result,
  output logic [XLEN-1:0]   op_mem_wdata,
  output logic [RA_W-1:0]   op_dest_reg,
  output logic [CTRL_W-1:0] op_ctrl
);
  localparam int SH_W = $clog2(XLEN);
  alu_op_e op;
  logic [XLEN-1:0] a, b_fwd, b, alu, hi, lo;
  logic [SH_W-1:0] sh, shv;
  logic [PC_W-1:0] target;
  logic busy, kill;
  assign op = alu_op_e'(ip_alu_op);
  assign a = ip_fa == FWD_MEM ? ip_fwd_mem : ip_fa == FWD_WB ? ip_fwd_wb : ip_rs1_data;
  assign b_fwd = ip_fb == FWD_MEM ? ip_fwd_mem : ip_fb == FWD_WB ? ip_fwd_wb : ip_rs2_data;
  assign b = ip_alu_src ? ip_immediate : b_fwd;
  assign sh = SH_W'(ip_shamt);
  assign shv = a[SH_W-1:0];
  assign target = ip_pc_plus_4 + (PC_W'(ip_immediate) << 2);
  assign op_stall = busy;
  assign kill = !ip_valid || ip_flush || busy;
  muldiv_iter #(.XLEN(XLEN)) u_md (
    .clock(clock),
    .reset(reset),
    .start(ip_valid && is_md_op(op)),
    .flush(ip_flush),
    .op(op),
    .a(a),
    .b(b),
    .busy(busy),
    .hi(hi),
    .lo(lo)
  );
  // single-cycle ALU; mul/div ops leave a zero result on their start cycle
  always_comb begin
    alu = '0;
    case (op)
      ALU_AND:  alu = a & b;
      ALU_OR:   alu = a | b;
      ALU_XOR:  alu = a ^ b;
      ALU_NOR:  alu = ~(a | b);
      ALU_ADD:  alu = a + b;
      ALU_SUB:  alu = a - b;
      ALU_SLT:  alu = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: alu = XLEN'(a < b);
      ALU_SLL:  alu = b << sh;
      ALU_SRL:  alu = b >> sh;
      ALU_SRA:  alu = $signed(b) >>> sh;
      ALU_SLLV: alu = b << shv;
      ALU_SRLV: alu = b >> shv;
      ALU_SRAV: alu = $signed(b) >>> shv;
      ALU_MFHI: alu = hi;
      ALU_MFLO: alu = lo;
      default:  alu = '0;
    endcase
  end
  // EX/MEM register: bubble (all zero) when empty, flushed or stalled behind mul/div
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      op_valid <= 1'b0;
      op_alu_result <= '0;
      op_zero <= 1'b0;
      op_add_result <= '0;
      op_mem_wdata <= '0;
      op_dest_reg <= '0;
      op_ctrl <= '0;
    end else begin
      op_valid <= !kill;
      op_alu_result <= kill ? '0 : alu;
      op_zero <= !kill && alu == '0;
      op_add_result <= kill ? '0 : target;
      op_mem_wdata <= kill ? '0 : b_fwd;
      op_dest_reg <= kill ? '0 : ip_dest_reg;
      op_ctrl <= kill ? '0 : ip_ctrl;
    end
endmodule

// File: tb/tb_execute_md_stage.sv
// tb_execute_md_stage: directed vectors checked against an arithmetic reference model and literal expectations
module tb_execute_md_stage;
  import exe_pkg::*;
  logic clock = 1'b0;
  logic reset;
  logic ip_valid, ip_flush, ip_alu_src;
  logic [4:0] ip_alu_op, ip_shamt, ip_dest_reg, ip_ctrl;
  logic [31:0] ip_rs1_data, ip_rs2_data, ip_immediate, ip_fwd_mem, ip_fwd_wb;
  logic [9:0] ip_pc_plus_4;
  logic [1:0] ip_fa, ip_fb;
  logic op_stall, op_valid, op_zero;
  logic [31:0] op_alu_result, op_mem_wdata;
  logic [9:0] op_add_result;
  logic [4:0] op_dest_reg, op_ctrl;
  int checks = 0;
  int errors = 0;

  execute_md_stage dut (
    .clock(clock), .reset(reset), .ip_valid(ip_valid), .ip_flush(ip_flush),
    .ip_alu_op(ip_alu_op), .ip_alu_src(ip_alu_src), .ip_rs1_data(ip_rs1_data),
    .ip_rs2_data(ip_rs2_data), .ip_immediate(ip_immediate), .ip_shamt(ip_shamt),
    .ip_pc_plus_4(ip_pc_plus_4), .ip_dest_reg(ip_dest_reg), .ip_ctrl(ip_ctrl),
    .ip_fa(ip_fa), .ip_fb(ip_fb), .ip_fwd_mem(ip_fwd_mem), .ip_fwd_wb(ip_fwd_wb),
    .op_stall(op_stall), .op_valid(op_valid), .op_alu_result(op_alu_result),
    .op_zero(op_zero), .op_add_result(op_add_result), .op_mem_wdata(op_mem_wdata),
    .op_dest_reg(op_dest_reg), .op_ctrl(op_ctrl)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(logic [1:0] s, logic [31:0] r, logic [31:0] m, logic [31:0] w);
    return s == 2'b10 ? m : s == 2'b01 ? w : r;
  endfunction

  function automatic logic [31:0] alu_model(logic [4:0] op, logic [31:0] a, logic [31:0] b,
                                            logic [4:0] sh, logic [31:0] hi, logic [31:0] lo);
    case (alu_op_e'(op))
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  return b << sh;
      ALU_SRL:  return b >> sh;
      ALU_SRA:  return $signed(b) >>> sh;
      ALU_SLLV: return b << a[4:0];
      ALU_SRLV: return b >> a[4:0];
      ALU_SRAV: return $signed(b) >>> a[4:0];
      ALU_MFHI: return hi;
      ALU_MFLO: return lo;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] md_model(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    case (alu_op_e'(op))
      ALU_MULT:  return 64'(sa * sb);
      ALU_MULTU: return {32'd0, a} * {32'd0, b};
      ALU_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      ALU_DIVU: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo, m_a, m_wd, m_b, m_alu;
  logic [63:0] m_prod;
  int m_left;
  logic m_kill;
  logic e_valid, e_zero;
  logic [31:0] e_res, e_wd;
  logic [9:0] e_add;
  logic [4:0] e_dest, e_ctrl;

  assign m_a = fwd(ip_fa, ip_rs1_data, ip_fwd_mem, ip_fwd_wb);
  assign m_wd = fwd(ip_fb, ip_rs2_data, ip_fwd_mem, ip_fwd_wb);
  assign m_b = ip_alu_src ? ip_immediate : m_wd;
  assign m_alu = alu_model(ip_alu_op, m_a, m_b, ip_shamt, m_hi, m_lo);
  assign m_kill = !ip_valid || ip_flush || m_left > 0;

  // reference model: a mul/div occupies the unit for 32 cycles after its start edge
  always @(posedge clock or posedge reset)
    if (reset) begin
      e_valid <= 0; e_zero <= 0; e_res <= 0; e_wd <= 0; e_add <= 0; e_dest <= 0; e_ctrl <= 0;
      m_hi <= 0; m_lo <= 0; m_prod <= 0; m_left <= 0;
    end else begin
      e_valid <= !m_kill;
      e_res <= m_kill ? 32'd0 : m_alu;
      e_zero <= !m_kill && m_alu == 0;
      e_wd <= m_kill ? 32'd0 : m_wd;
      e_add <= m_kill ? 10'd0 : 10'(ip_pc_plus_4 + 10'(ip_immediate * 4));
      e_dest <= m_kill ? 5'd0 : ip_dest_reg;
      e_ctrl <= m_kill ? 5'd0 : ip_ctrl;
      if (m_left > 0) begin
        m_left <= ip_flush ? 0 : m_left - 1;
        if (!ip_flush && m_left == 1) {m_hi, m_lo} <= m_prod;
      end else if (ip_valid && !ip_flush && is_md_op(alu_op_e'(ip_alu_op))) begin
        m_prod <= md_model(ip_alu_op, m_a, m_b);
        m_left <= 32;
      end
    end

  always @(negedge clock) begin
    chk("stall", 32'(op_stall), 32'(m_left > 0));
    chk("valid", 32'(op_valid), 32'(e_valid));
    chk("alu_result", op_alu_result, e_res);
    chk("zero", 32'(op_zero), 32'(e_zero));
    chk("add_result", 32'(op_add_result), 32'(e_add));
    chk("mem_wdata", op_mem_wdata, e_wd);
    chk("dest_reg", 32'(op_dest_reg), 32'(e_dest));
    chk("ctrl", 32'(op_ctrl), 32'(e_ctrl));
  end

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] sh = 0);
    ip_valid = 1; ip_flush = 0; ip_alu_op = op; ip_rs1_data = r1; ip_rs2_data = r2; ip_shamt = sh;
    ip_alu_src = 0; ip_fa = 0; ip_fb = 0; ip_immediate = 32'h10; ip_pc_plus_4 = 10'h104;
    ip_dest_reg = 5'd9; ip_ctrl = 5'b01000;
  endtask

  task automatic md_check(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo_e, input logic [31:0] hi_e);
    int n;
    issue(op, a, b);
    cyc;
    chk({nm, "_start_valid"}, 32'(op_valid), 32'd1);
    chk({nm, "_start_res"}, op_alu_result, 32'd0);
    issue(ALU_MFLO, 0, 0);
    n = 0;
    while (op_stall && n < 40) begin
      n++;
      cyc;
    end
    chk({nm, "_stall_cycles"}, n, 32);
    cyc;
    chk({nm, "_lo"}, op_alu_result, lo_e);
    issue(ALU_MFHI, 0, 0);
    cyc;
    chk({nm, "_hi"}, op_alu_result, hi_e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1;
    issue(ALU_ADD, 0, 0);
    ip_valid = 0;
    ip_fwd_mem = 32'h10;
    ip_fwd_wb = 32'h99;
    repeat (2) cyc;
    chk("rst_valid", 32'(op_valid), 0);
    chk("rst_stall", 32'(op_stall), 0);
    chk("rst_result", op_alu_result, 0);
    reset = 0;
    issue(ALU_ADD, 32'h7FFFFFFF, 32'h1); cyc;
    chk("add_ovf", op_alu_result, 32'h80000000);
    chk("add_ovf_zero", 32'(op_zero), 0);
    chk("add_pc", 32'(op_add_result), 32'h144);
    issue(ALU_SUB, 5, 5); cyc;
    chk("sub_res", op_alu_result, 0);
    chk("sub_zero", 32'(op_zero), 1);
    issue(ALU_SLT, 32'hFFFFFFFF, 1); cyc;
    chk("slt", op_alu_result, 1);
    issue(ALU_SLTU, 32'hFFFFFFFF, 1); cyc;
    chk("sltu", op_alu_result, 0);
    issue(ALU_ADD, 32'h1234, 32'h5678);
    ip_fa = 2'b10; ip_fb = 2'b01; ip_alu_src = 1; ip_immediate = 4; cyc;
    chk("fwd_add", op_alu_result, 32'h14);
    chk("fwd_wdata", op_mem_wdata, 32'h99);
    issue(ALU_SRA, 0, 32'h80000000, 4); cyc;
    chk("sra", op_alu_result, 32'hF8000000);
    issue(ALU_SRL, 0, 32'h80000000, 31); cyc;
    chk("srl", op_alu_result, 1);
    issue(ALU_SLLV, 36, 1); cyc;
    chk("sllv", op_alu_result, 32'h10);
    issue(ALU_NOR, 0, 0); cyc;
    chk("nor", op_alu_result, 32'hFFFFFFFF);
    issue(ALU_SRAV, 33, 32'h80000000); cyc;
    issue(ALU_XOR, 32'hF0F0, 32'h0FF0); cyc;
    ip_valid = 0; cyc;
    chk("bubble_valid", 32'(op_valid), 0);
    chk("bubble_ctrl", 32'(op_ctrl), 0);
    md_check("mult", ALU_MULT, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 32'hFFFFFFFF);
    md_check("multu", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE);
    md_check("div", ALU_DIV, 32'hFFFFFFF9, 2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    md_check("divu0", ALU_DIVU, 7, 0, 32'hFFFFFFFF, 7);
    md_check("divmin", ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    issue(ALU_MULT, 3, 5); cyc;
    repeat (9) cyc;
    chk("flush_pre_stall", 32'(op_stall), 1);
    ip_flush = 1; cyc;
    chk("flush_stall", 32'(op_stall), 0);
    chk("flush_valid", 32'(op_valid), 0);
    issue(ALU_MFLO, 0, 0); cyc;
    chk("flush_lo", op_alu_result, 32'h80000000);
    issue(ALU_MFHI, 0, 0); cyc;
    chk("flush_hi", op_alu_result, 0);
    issue(ALU_MULTU, 32'hFFFF, 32'hFFFF); cyc;
    chk("arst_pre_valid", 32'(op_valid), 1);
    #2 reset = 1;
    #1;
    chk("arst_valid", 32'(op_valid), 0);
    chk("arst_stall", 32'(op_stall), 0);
    chk("arst_ctrl", 32'(op_ctrl), 0);
    chk("arst_add", 32'(op_add_result), 0);
    #2 reset = 0;
    issue(ALU_MFLO, 0, 0); cyc;
    chk("arst_lo", op_alu_result, 0);
    issue(ALU_MFHI, 0, 0); cyc;
    chk("arst_hi", op_alu_result, 0);
    issue(ALU_ADD, 1, 2);
    ip_pc_plus_4 = 10'h3FC; ip_immediate = 1; cyc;
    chk("pc_wrap", 32'(op_add_result), 0);
    chk("pc_wrap_res", op_alu_result, 3);
    ip_valid = 0;
    repeat (3) cyc;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
